// File: rtl/wb_regfile.sv
// Write-back stage register file: selects the MEM/WB result, commits it into a
// 2**ADDR_WIDTH-entry file, and serves two ID read ports plus a debug port with write-through bypass.
module wb_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  CLOCK,
   input  logic                  RESET_N,
   input  logic                  RegWriteEN_In,
   input  logic                  Mem2RegSEL_In,
   input  logic [DATA_WIDTH-1:0] ALUResult_In,
   input  logic [DATA_WIDTH-1:0] MemResult_In,
   input  logic [ADDR_WIDTH-1:0] WriteBackRegAddr_In,
   input  logic [ADDR_WIDTH-1:0] ReadAddr1_In,
   input  logic [ADDR_WIDTH-1:0] ReadAddr2_In,
   input  logic [ADDR_WIDTH-1:0] DebugAddr_In,
   output logic [DATA_WIDTH-1:0] ReadData1_Out,
   output logic [DATA_WIDTH-1:0] ReadData2_Out,
   output logic [DATA_WIDTH-1:0] DebugData_Out,
   output logic [DATA_WIDTH-1:0] WriteBackData_Out,
   output logic [CNT_WIDTH-1:0]  WriteCount_Out
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-1];
   logic [CNT_WIDTH-1:0]  write_count;
   logic                  commit;

   assign WriteBackData_Out = Mem2RegSEL_In ? MemResult_In : ALUResult_In;

   // Gating with RESET_N keeps a commit that coincides with reset from leaking through the bypass.
   assign commit = RegWriteEN_In && (WriteBackRegAddr_In != '0) && RESET_N;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         write_count <= '0;
      end else if (commit) begin
         regs[WriteBackRegAddr_In] <= WriteBackData_Out;
         write_count <= write_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
      logic [DATA_WIDTH-1:0] value;
      value = '0;
      if (addr == '0) begin
         value = '0;
      end else if (commit && (WriteBackRegAddr_In == addr)) begin
         value = WriteBackData_Out;
      end else begin
         value = regs[addr];
      end
      return value;
   endfunction

   assign ReadData1_Out  = read_port(ReadAddr1_In);
   assign ReadData2_Out  = read_port(ReadAddr2_In);
   assign DebugData_Out  = read_port(DebugAddr_In);
   assign WriteCount_Out = write_count;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB stage boundary. Consumes the MEM/WB register outputs, selects the write-back value, and commits it into a 32-entry general-purpose register file.
- Provides two ID-stage read ports with same-cycle write-through bypass, plus a debug read port and a committed-write counter.
- Sits between the MEM/WB register and the ID stage / forwarding unit.

Parameters:
DATA_WIDTH, 32, register and data-path width
ADDR_WIDTH, 5, register address width; the file has 2**ADDR_WIDTH entries
CNT_WIDTH, 32, width of committed-write counter

Ports:
CLOCK  input  1  rising-edge clock
RESET_N  input  1  asynchronous active-low reset
RegWriteEN_In  input  1  write-back enable from MEM/WB
Mem2RegSEL_In  input  1  1 selects MemResult_In, 0 selects ALUResult_In
ALUResult_In  input  DATA_WIDTH  ALU result from MEM/WB
MemResult_In  input  DATA_WIDTH  load data from MEM/WB
WriteBackRegAddr_In  input  ADDR_WIDTH  destination register
ReadAddr1_In  input  ADDR_WIDTH  ID read port 1 address
ReadAddr2_In  input  ADDR_WIDTH  ID read port 2 address
DebugAddr_In  input  ADDR_WIDTH  debug read address
ReadData1_Out  output  DATA_WIDTH  read port 1 data
ReadData2_Out  output  DATA_WIDTH  read port 2 data
DebugData_Out  output  DATA_WIDTH  debug port data
WriteBackData_Out  output  DATA_WIDTH  selected write-back value, for the forwarding mux
WriteCount_Out  output  CNT_WIDTH  number of committed writes

Behaviour:
- Reset: RESET_N low asynchronously clears all registers to 0 and sets WriteCount_Out to 0. This holds while RESET_N is low and overrides CLOCK. Deassertion takes effect from the next rising edge.
- Write-back select (combinational): WriteBackData_Out = Mem2RegSEL_In ? MemResult_In : ALUResult_In. It is valid regardless of RegWriteEN_In.
- Commit: a write commits when RegWriteEN_In = 1 and WriteBackRegAddr_In != 0. On the rising CLOCK edge, the register at WriteBackRegAddr_In takes WriteBackData_Out and WriteCount_Out increments by 1.
  - No commit leaves the file and the counter unchanged.
  - The counter wraps from all-ones to 0 with no flag.
- Register 0: never written. Any read of address 0 returns 0, including under bypass conditions.
- Read ports 1 and 2 (combinational, zero latency), evaluated in priority order:
  - addr = 0 -> 0
  - else if a commit is pending this cycle to the same address -> WriteBackData_Out (write-through bypass)
  - else -> stored register value
- Both read ports may hit the same address and the same bypass simultaneously. Both then return the identical value.
- Debug port: same rule as the read ports, including bypass.
- Timing: a write in cycle N is visible via bypass in cycle N and from storage in cycle N+1 onward.
- Reset mid-operation: a commit pending on the same edge that RESET_N is low is discarded. After release, all reads return 0 until the first new commit.
- Unused inputs with X while RegWriteEN_In = 0 must not corrupt state.

Test Plan:
- Reset: RESET_N low while RegWriteEN_In=1, addr=5, ALUResult=0xDEADBEEF, several clocks -> after release, ReadData1(addr 5)=0 and WriteCount_Out=0.
- Select and commit: RegWriteEN=1, Mem2RegSEL=1, MemResult=0x12345678, ALUResult=0xAAAAAAAA, addr=7, one edge; then RegWriteEN=0 -> ReadData1(7)=0x12345678 and WriteCount_Out=1. Repeat with Mem2RegSEL=0 to addr 8 -> ReadData2(8)=0xAAAAAAAA.
- Register 0: RegWriteEN=1, addr=0, ALUResult=0xFFFFFFFF -> in the same cycle ReadData1(0)=0; after the edge ReadData1(0)=0 and WriteCount_Out unchanged.
- Bypass: reg 3 holds 0x11. RegWriteEN=1, addr=3, ALUResult=0x22, ReadAddr1=ReadAddr2=DebugAddr=3 -> all three outputs read 0x22 before the edge. With RegWriteEN=0 and the same inputs, all three read 0x11.
- Async reset mid-run: write 0x55 to reg 9, then pulse RESET_N low between clock edges -> ReadData1(9) drops to 0 immediately, without waiting for a clock edge.
- Counter wrap: force WriteCount_Out to 0xFFFFFFFF via 2**32-1 commits (or CNT_WIDTH=4 with 15 commits), then one more commit -> WriteCount_Out=0.
